// File: rtl/sysid_checker.sv
// System ID / build-timestamp checker: reads two Avalon-MM registers after reset or on start.
// Optional stall watchdog compiled in with `define SYSID_CHECKER_TIMEOUT_EN.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h11223344,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h518EBB60,
  parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] read_id,
  output logic [31:0] read_ts
);

  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, FIN} state_t;

  state_t state_q, state_d;
  logic   auto_run_q;
  logic   stall_expired;

`ifdef SYSID_CHECKER_TIMEOUT_EN
  localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] stall_cnt_q;

  // Counts stall cycles of the current read; restarts whenever the FSM changes state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (state_d != state_q) begin
      stall_cnt_q <= '0;
    end else if (busy && avm_waitrequest) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_expired = busy && avm_waitrequest && (stall_cnt_q == STALL_LIMIT);
`else
  logic [31:0] unused_timeout_cfg;

  assign unused_timeout_cfg = TIMEOUT_CYCLES;
  assign stall_expired      = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      auto_run_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == RD_ID) begin
        auto_run_q <= 1'b0;
      end
    end
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start || auto_run_q) state_d = RD_ID;
      RD_ID: begin
        if (stall_expired)         state_d = FIN;
        else if (!avm_waitrequest) state_d = RD_TS;
      end
      RD_TS: begin
        if (stall_expired || !avm_waitrequest) state_d = FIN;
      end
      FIN:     if (start) state_d = RD_ID;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they change only on clock edges.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      read_id     <= '0;
      read_ts     <= '0;
    end else begin
      avm_read    <= (state_d == RD_ID) || (state_d == RD_TS);
      busy        <= (state_d == RD_ID) || (state_d == RD_TS);
      avm_address <= (state_d == RD_TS);
      done        <= (state_d == FIN);

      if (state_q != RD_ID && state_d == RD_ID) begin
        id_ok   <= 1'b0;
        ts_ok   <= 1'b0;
        timeout <= 1'b0;
      end

      if (stall_expired) begin
        timeout <= 1'b1;
        id_ok   <= 1'b0;
        ts_ok   <= 1'b0;
        read_ts <= '0;
        if (state_q == RD_ID) read_id <= '0;
      end else if (state_q == RD_ID && !avm_waitrequest) begin
        read_id <= avm_readdata;
      end else if (state_q == RD_TS && !avm_waitrequest) begin
        // ID word is already registered; timestamp is compared as it is captured.
        read_ts <= avm_readdata;
        id_ok   <= (read_id == EXPECTED_ID);
        ts_ok   <= (avm_readdata == EXPECTED_TIMESTAMP);
      end
    end
  end

endmodule

// File: doc/sysid_checker.md
SYSID_CHECKER -- requirements
Module: sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 32'h11223344, system ID value the checker compares against.
REQ-002 Parameter EXPECTED_TIMESTAMP, default 32'h518EBB60, build timestamp value the checker compares against.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, maximum consecutive waitrequest cycles per read (range 2..65535).
REQ-004 clock  input  1  sole clock; all state on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to (re)run the check.
REQ-007 avm_address  output  1  Avalon-MM word address: 0 = ID register, 1 = timestamp register.
REQ-008 avm_read  output  1  Avalon-MM read strobe.
REQ-009 avm_readdata  input  32  read data, valid in the cycle avm_read=1 and avm_waitrequest=0.
REQ-010 avm_waitrequest  input  1  slave stall; tie 0 for zero-wait slaves.
REQ-011 busy  output  1  check in progress.
REQ-012 done  output  1  check finished; held until next run starts.
REQ-013 id_ok  output  1  captured ID equals EXPECTED_ID.
REQ-014 ts_ok  output  1  captured timestamp equals EXPECTED_TIMESTAMP.
REQ-015 timeout  output  1  a read was abandoned after TIMEOUT_CYCLES stall cycles.
REQ-016 read_id  output  32  last captured ID word.
REQ-017 read_ts  output  32  last captured timestamp word.

Function
REQ-018 FSM states SHALL be IDLE, RD_ID, RD_TS, FIN; all outputs registered.
REQ-019 IDLE -> RD_ID when start=1 or the auto-run flag is set; auto-run flag SHALL clear on that transition.
REQ-020 RD_ID SHALL drive avm_read=1, avm_address=0; on the avm_waitrequest=0 cycle capture avm_readdata into read_id and go to RD_TS.
REQ-021 RD_TS SHALL drive avm_read=1, avm_address=1; on the avm_waitrequest=0 cycle capture into read_ts and go to FIN.
REQ-022 avm_address and avm_read SHALL remain stable while avm_waitrequest=1.
REQ-023 With zero-wait slave, start at cycle N SHALL give reads at N+1, N+2 and done=1 at N+3.
REQ-024 In FIN: done=1, busy=0, avm_read=0; id_ok/ts_ok reflect registered compares of read_id/read_ts.
REQ-025 start in FIN SHALL go to RD_ID and clear done, id_ok, ts_ok, timeout that cycle.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 busy=1 exactly in RD_ID and RD_TS.
REQ-028 One avm_read deasserted cycle SHALL NOT be inserted between the two reads (back-to-back).

Reset
REQ-029 reset=1 SHALL immediately force IDLE, avm_read=0, avm_address=0, busy=0, done=0, id_ok=0, ts_ok=0, timeout=0, read_id=0, read_ts=0.
REQ-030 reset SHALL set the auto-run flag, so one check starts in the first clock after reset deasserts without start.
REQ-031 reset mid-read SHALL abandon the transaction; no capture occurs.

Configuration
REQ-032 Macro SYSID_CHECKER_TIMEOUT_EN SHALL compile in the stall watchdog.
REQ-033 With macro: a 16-bit counter resets on each state entry, increments per avm_waitrequest=1 cycle; on reaching TIMEOUT_CYCLES the FSM SHALL drop avm_read, go to FIN with timeout=1, id_ok=0, ts_ok=0, uncaptured words left at 0.
REQ-034 Without macro: no counter; reads wait indefinitely; timeout SHALL be constant 0.

Verification
REQ-035 Zero-wait slave returning 32'h11223344 / 32'h518EBB60, release reset -> reads at cycles 1,2 after release, done=1, id_ok=1, ts_ok=1 at cycle 3.
REQ-036 Slave returns ID 32'hDEADBEEF -> done=1, id_ok=0, ts_ok=1, read_id=32'hDEADBEEF.
REQ-037 waitrequest held 5 cycles on address 0 -> address/read stable for 5 cycles, capture on 6th, check passes.
REQ-038 (macro on, TIMEOUT_CYCLES=8) waitrequest stuck 1 -> after 8 stall cycles avm_read=0, done=1, timeout=1, id_ok=0.
REQ-039 start pulsed during RD_TS -> ignored; start pulsed in FIN -> done drops next cycle, new two-read sequence runs.
REQ-040 reset asserted during RD_TS -> all outputs 0 asynchronously; after release a fresh auto-run completes.
